// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. The block takes two WIDTH-bit
// operands over a valid/ready handshake and computes a - b LSB-first, one bit
// per clock. It uses a single full-adder slice and a carry flop. The result
// is presented with an unsigned borrow and a signed overflow flag on a
// valid/ready output.
//
// Parameters:
//   WIDTH      operand/result width in bits (2..32), default 8
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands a/b valid
//   in_ready   block can accept operands (high in IDLE)
//   a          minuend
//   b          subtrahend
//   out_valid  diff/borrow/ovf valid (high in DONE)
//   out_ready  consumer accepts result
//   diff       a - b modulo 2^WIDTH
//   borrow     unsigned a < b (carry-out in add mode)
//   ovf        signed overflow of the operation
//   op         only with SERIAL_SUB_ADD_MODE_EN: 0 = subtract, 1 = add
//
// Optional feature macro: SERIAL_SUB_ADD_MODE_EN
//   When this macro is defined, the op port exists and is latched at accept.
//   With op=1, the block adds instead of subtracting.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  // The partial result holds the WIDTH-1 low bits already produced. The MSB
  // is combined in on the final RUN cycle, so diff only changes when a
  // complete result exists.
  logic [WIDTH-2:0]   res_q, res_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic               ovf_q, ovf_d;
  logic               op_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic               op_d;
`endif

  logic               b_bit;
  logic [1:0]         slice;   // {carry_out, sum}
  logic [WIDTH-1:0]   res_shift;

  // Single full-adder slice: returns {majority carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic cin);
    full_add = {(x & y) | (x & cin) | (y & cin), x ^ y ^ cin};
  endfunction

  // Subtract: a + ~b + 1. Add: a + b + 0. The op bit selects whether the
  // subtrahend is inverted.
  assign b_bit     = sb_q[0] ^ ~op_q;
  assign slice     = full_add(sa_q[0], b_bit, c_q);
  assign res_shift = {slice[0], res_q};

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_d     = op_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sa_d  = a;
          sb_d  = b;
          cnt_d = '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
          op_d  = op;
          c_d   = ~op;
`else
          c_d   = 1'b1;
`endif
          state_d = RUN;
        end
      end

      RUN: begin
        res_d = res_shift[WIDTH-1:1];
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = slice[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          diff_d   = res_shift;
          // In subtract mode the borrow is the inverted carry-out. In add
          // mode the carry-out itself is reported.
          borrow_d = slice[1] ^ ~op_q;
          // The carry into the MSB differs from the carry out of the MSB.
          ovf_d    = c_q ^ slice[1];
          state_d  = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---- state / datapath registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SERIAL_SUB_ADD_MODE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= 1'b0;
    end else begin
      op_q <= op_d;
    end
  end
`else
  assign op_q = 1'b0;
`endif

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed testbench for serial_subtractor at WIDTH=8. Expected values are
// computed by hand. The bench ends with a single summary line.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op        (op),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits for in_ready, issues one operation, checks the latency and the
  // result, and then consumes the result. The task is entered and left #1
  // after a rising edge.
  task automatic do_op(input string tag, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic vop,
                       input logic [W-1:0] ed, input logic eb,
                       input logic eo);
    int lat;
    int guard;
    a = va; b = vb; op = vop; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;               // accept edge E0
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"},    lat,           W);
    chk({tag, "_diff"},   32'(diff),     32'(ed));
    chk({tag, "_borrow"}, 32'(borrow),   32'(eb));
    chk({tag, "_ovf"},    32'(ovf),      32'(eo));
    out_ready = 1'b1;
    @(posedge clk); #1;               // output handshake
    out_ready = 1'b0;
    chk({tag, "_ovdrop"}, 32'(out_valid), 32'd0);
    chk({tag, "_irdy"},   32'(in_ready),  32'd1);
  endtask

  initial begin : main
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] ed [3];
    logic         eb [3];
    logic         eo [3];
    int           tacc [3];
    int           guard;
    logic         seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff",      32'(diff),      32'd0);
    chk("rst_borrow",    32'(borrow),    32'd0);
    chk("rst_ovf",       32'(ovf),       32'd0);

    do_op("sub_5_3", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op("sub_3_5", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    do_op("sub_80_1", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

    // Apply backpressure in DONE while a new operand request is pending.
    a = 8'h00; b = 8'h00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    chk("bp_valid0", 32'(out_valid), 32'd1);
    a = 8'h11; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_diff",  32'(diff),      32'd0);
      chk("bp_hold_rdy",   32'(in_ready),  32'd0);
    end
    chk("bp_borrow", 32'(borrow), 32'd0);
    chk("bp_ovf",    32'(ovf),    32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_irdy",   32'(in_ready),  32'd1);
    chk("bp_ovdrop", 32'(out_valid), 32'd0);
    chk("bp_diff_kept", 32'(diff), 32'd0);

    // Reset is sampled on the edge that ends the 4th RUN cycle.
    a = 8'h40; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;               // E0
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_irdy",  32'(in_ready),  32'd1);
    chk("abort_ov",    32'(out_valid), 32'd0);
    chk("abort_diff",  32'(diff),      32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_pulse", 32'(seen), 32'd0);
    do_op("after_abort", 8'h40, 8'h20, 1'b0, 8'h20, 1'b0, 1'b0);

    // Back-to-back issue with out_ready held high.
    va = '{8'h10, 8'h7F, 8'hC8};
    vb = '{8'h20, 8'hFF, 8'h64};
    ed = '{8'hF0, 8'h80, 8'h64};
    eb = '{1'b1, 1'b1, 1'b0};
    eo = '{1'b0, 1'b1, 1'b1};
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = va[i]; b = vb[i];
      guard = 0;
      while (!in_ready && guard < 40) begin
        @(posedge clk); #1; guard++;
      end
      chk("b2b_rdy", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      tacc[i] = cyc;
      if (i == 2) in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin
        @(posedge clk); #1; guard++;
      end
      chk("b2b_diff",   32'(diff),   32'(ed[i]));
      chk("b2b_borrow", 32'(borrow), 32'(eb[i]));
      chk("b2b_ovf",    32'(ovf),    32'(eo[i]));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_gap01", tacc[1] - tacc[0], W + 2);
    chk("b2b_gap12", tacc[2] - tacc[1], W + 2);

`ifdef SERIAL_SUB_ADD_MODE_EN
    do_op("add_ff_1", 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op("add_7f_1", 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b1);
    do_op("op0_sub",  8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor, the inverse-direction companion to the team's parallel adder datapath. It accepts two WIDTH-bit operands over a valid/ready handshake and computes `a - b` LSB-first, one bit per clock, using a single full-adder slice and a borrow/carry flop. It then presents the difference, an unsigned borrow and a signed overflow flag on a valid/ready output. It trades latency for area in the Tiny Tapeout user design.

## Interface

Parameters:
- `WIDTH`, default 8: operand/result width in bits; legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operands `a`/`b` are valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, WIDTH: minuend.
- `b`, input, WIDTH: subtrahend.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, WIDTH: `a - b` modulo 2^WIDTH.
- `borrow`, output, 1: unsigned `a < b`.
- `ovf`, output, 1: signed overflow of `a - b`.
- `op`, input, 1: present only with `SERIAL_SUB_ADD_MODE_EN`; 0 = subtract, 1 = add.

## Operation

- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `diff`=0, `borrow`=0, `ovf`=0. The counter, the shift registers and the carry flop are cleared.
- IDLE: `in_ready`=1.
  - On `in_valid & in_ready`: latch `a` into shift register SA and `b` into SB.
  - Set carry flop c=1.
  - Clear bit counter `cnt` and go to RUN.
- RUN: `in_ready`=0, `out_valid`=0. Each cycle:
  - Compute s = SA[0] ^ ~SB[0] ^ c.
  - Compute c' = maj(SA[0], ~SB[0], c).
  - Shift s into the result register from the MSB end.
  - Shift SA and SB right by one and increment `cnt`.
- At the RUN cycle with `cnt` == WIDTH-1:
  - `borrow` <= ~c'.
  - `ovf` <= c ^ c', where c is the carry into the MSB.
  - Go to DONE.
- DONE: `out_valid`=1.
  - `diff`, `borrow` and `ovf` are held stable.
  - On `out_valid & out_ready`, go to IDLE. `out_valid` drops on the next cycle.
- `in_valid` is ignored in RUN and DONE. There is no operand queueing.
- `diff`, `borrow` and `ovf` keep their last values after DONE until the next result overwrites them.
- Reset asserted in any state, including mid-RUN:
  - The next state is IDLE with all reset values.
  - The partial result is discarded.
  - No `out_valid` pulse is emitted for the aborted operation.

## Timing

- Accept edge = E0 (`in_valid & in_ready` sampled high).
- RUN occupies edges E1..E_WIDTH.
- `out_valid` is high from the cycle after E_WIDTH.
- Latency is WIDTH cycles from accept to `out_valid`.
- `in_ready` is low from the cycle after E0 until the cycle after the output handshake.
- No same-cycle output-consume/input-accept.
- Minimum issue interval: WIDTH+2 cycles.
- `out_ready` may be held low indefinitely; outputs remain constant while `out_valid`=1.
- `out_ready` high in IDLE or RUN has no effect.

## Configuration

- `SERIAL_SUB_ADD_MODE_EN` defined:
  - Port `op` exists and is latched at accept.
  - With `op`=1 the slice uses SB[0] (not inverted) and an initial c=0, so the block computes `a + b`.
  - In add mode, `borrow` reports unsigned carry-out and `ovf` reports signed add overflow.
  - With `op`=0 the behaviour is identical to subtract.
- Not defined: no `op` port; the block always subtracts.

## Test plan

- WIDTH=8, a=0x05, b=0x03: `out_valid` exactly 8 cycles after accept, `diff`=0x02, `borrow`=0, `ovf`=0.
- a=0x03, b=0x05: `diff`=0xFE, `borrow`=1, `ovf`=0. Then a=0x80, b=0x01: `diff`=0x7F, `borrow`=0, `ovf`=1.
- Backpressure, a=0x00, b=0x00:
  - Hold `out_ready`=0 for 5 cycles in DONE.
  - `diff`=0x00 and `out_valid`=1 are held; `in_ready`=0.
  - A concurrent `in_valid` with a=0x11 is ignored.
  - After `out_ready`=1, `in_ready`=1 on the following cycle.
- Reset at the 4th RUN cycle of a=0x40, b=0x20:
  - Next cycle `in_ready`=1, `out_valid`=0, `diff`=0.
  - A subsequent a=0x40, b=0x20 gives `diff`=0x20.
- Back-to-back: issue 3 operations with `out_ready` tied high. Each result appears at the correct value, with accepts spaced WIDTH+2 cycles apart.
- With `SERIAL_SUB_ADD_MODE_EN`:
  - `op`=1, a=0xFF, b=0x01 gives `diff`=0x00, `borrow`=1, `ovf`=0.
  - `op`=1, a=0x7F, b=0x01 gives `diff`=0x80, `ovf`=1.
